// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky trap state.
// Moore outputs on (state, opcode); FETCH strobes are qualified by mem_ready; all outputs are forced low while rst is high.
module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_c,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic             w_legal;
  logic             w_timeout;
  logic             w_is_store;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
      default:                           w_legal = 1'b0;
    endcase
  end

  assign w_is_store = (opcode == OP_STORE);
  // The limit is hit on the cycle whose increment would bring the count to TIMEOUT.
  assign w_timeout  = (TIMEOUT != 0) && !mem_ready && (r_cnt == CNT_W'(LIM));

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_c  = 1'b0;
    pc_src      = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_op      = '0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    trap        = 1'b0;
    trap_cause  = 2'b00;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd2;
        if (w_legal) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = 2'b01;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
        case (opcode)
          OP_R: begin
            alu_src_a = 2'd1;
            alu_op    = ALUOP_W'(2);
          end
          OP_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = ALUOP_W'(2);
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a   = 2'd1;
            alu_src_b   = 2'd2;
            w_state_nxt = S_MEM;
          end
          OP_BR: begin
            alu_src_a   = 2'd1;
            alu_op      = ALUOP_W'(1);
            pc_write_c  = 1'b1;
            pc_src      = 2'd1;
            w_state_nxt = S_FETCH;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          OP_JALR: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
          end
          OP_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
          end
          default: begin
            alu_src_b = 2'd2;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = w_is_store;
        if (mem_ready) begin
          w_state_nxt = w_is_store ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = 2'b10;
        end
      end
      S_WB: begin
        reg_write   = 1'b1;
        w_state_nxt = S_FETCH;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'd1;
        end else if (opcode == OP_JAL || opcode == OP_JALR) begin
          wb_sel = 2'd2;
        end
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = r_cause;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Reset silences the memory port immediately, not at the next edge.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_write_c = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = '0;
      reg_write  = 1'b0;
      wb_sel     = 2'd0;
      trap       = 1'b0;
      trap_cause = 2'b00;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if ((w_state_nxt != r_state) && (w_state_nxt == S_FETCH || w_state_nxt == S_MEM)) begin
      w_cnt_nxt = '0;
    end else if ((TIMEOUT != 0) && (r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

endmodule
